fft_frame_controller: RTL and testbench
=======================================

# fft_frame_controller

Sequencer between the UART byte link and the 16-point FFT core. It collects FFT_SIZE signed sample bytes from the UART receiver and writes them into the FFT input buffer as fixed-point words. It then starts one FFT cycle, waits for completion, and streams every output bin (real, then imaginary, MSB byte first) to the UART transmitter one byte per TX handshake. After the frame it re-arms for the next one.

## Interface
Parameters:
- FFT_SIZE, 16, number of points; power of two
- WORD_SIZE, 16, FFT word width; multiple of DATA_LENGTH
- DATA_LENGTH, 8, UART byte width
- FRACTION, 8, fractional bits of FFT fixed-point format

Ports (AW = $clog2(FFT_SIZE), BPW = WORD_SIZE/DATA_LENGTH):
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rx_valid  in  1  one-cycle pulse, received byte valid
- i_rx_byte  in  DATA_LENGTH  received byte, two's complement sample
- o_sample_we  out  1  input-buffer write strobe
- o_sample_addr  out  AW  input-buffer write address
- o_sample_data  out  WORD_SIZE  sign_extend(byte) << FRACTION, truncated to WORD_SIZE
- o_fft_start  out  1  one-cycle FFT start pulse
- i_fft_done  in  1  one-cycle pulse, FFT results valid
- o_res_addr  out  AW  result read address; result RAM has 1-cycle read latency
- i_res_re, i_res_im  in  WORD_SIZE each  result word at o_res_addr from the previous cycle
- o_tx_start  out  1  one-cycle UART TX start pulse
- o_tx_byte  out  DATA_LENGTH  byte to send; held stable from start until i_tx_done
- i_tx_done  in  1  one-cycle pulse, TX byte finished
- o_busy  out  1  high except in RECV with sample count 0
- o_frame_done  out  1  one-cycle pulse after the last byte of a frame
- o_error  out  1  sticky overrun flag; cleared only by i_rst

## Operation
- States: RECV, START, WAIT_FFT, READ, LATCH, SEND, WAIT_TX.
- RECV: on each i_rx_valid, write the converted sample at address smp_cnt and increment smp_cnt. On the FFT_SIZE-th byte, go to START with smp_cnt wrapped to 0.
- START: assert o_fft_start for 1 cycle, then go to WAIT_FFT.
- WAIT_FFT: on i_fft_done, set bin = 0 and go to READ. i_fft_done in any other state is ignored.
- READ: drive o_res_addr = bin, then go to LATCH.
- LATCH: capture {i_res_re, i_res_im} into a 2*WORD_SIZE shift register, set byte_cnt = 0, go to SEND.
- SEND: o_tx_byte = shift register MSBs; assert o_tx_start for 1 cycle; go to WAIT_TX.
- WAIT_TX: on i_tx_done, shift left by DATA_LENGTH and increment byte_cnt. Next state:
  - byte_cnt < 2*BPW: SEND
  - bin < FFT_SIZE-1: bin+1, READ
  - otherwise: pulse o_frame_done, return to RECV
- Per bin, the byte order is re[MSB..LSB] then im[MSB..LSB]. A frame is FFT_SIZE*2*BPW bytes (64 at defaults).
- Overrun: i_rx_valid in any state other than RECV drops the byte, sets o_error, and produces no write.
- Reset values: all outputs 0, state RECV, all counters 0. Reset mid-frame aborts immediately. A stale i_tx_done or i_fft_done arriving after reset is ignored.

## Timing
- Write latency: i_rx_valid at cycle t gives o_sample_we, addr and data registered at t+1, each for exactly 1 cycle.
- FFT start: last sample byte at t gives o_fft_start at t+2.
- First TX byte: i_fft_done at d gives READ at d+1 (o_res_addr valid), LATCH at d+2, o_tx_start at d+3.
- Byte-to-byte: i_tx_done at c gives the next o_tx_start at c+1 within a bin. Across bins it is c+3 (READ, LATCH, SEND).
- Frame end: o_frame_done is asserted in the cycle after the final i_tx_done. RECV accepts a byte in the following cycle.
- A byte arriving in the same cycle as the START transition counts as overrun.

## Test plan
- Send bytes 0x00..0x0F: writes addr k with data k<<8 at t+1; single o_fft_start 2 cycles after the 16th byte; no o_error.
- Send 0xFF and 0x80: data 0xFF00 and 0x8000 (sign-extended).
- Pulse i_fft_done with bin0 re=0x1234, im=0xABCD: o_tx_start at d+3 with bytes 0x12, 0x34, 0xAB, 0xCD in that order; o_res_addr steps 0..15.
- Full frame with TX model (done 10 cycles after start): exactly 64 o_tx_start pulses, one o_frame_done, o_busy low afterwards. A second 16-byte frame is accepted with addresses starting at 0.
- Send a byte during WAIT_FFT: o_error=1, no o_sample_we; o_error stays 1 through the next frame.
- Assert i_rst during WAIT_TX of bin 5: all outputs 0 next cycle; the late i_tx_done is ignored; the next rx byte is written at addr 0.

Source files
------------

// File: rtl/fft_frame_controller.sv
// fft_frame_controller: collects UART sample bytes into the FFT input buffer, runs one FFT,
// then streams every result bin (re then im, MSB byte first) back out over UART TX.
module fft_frame_controller #(
   parameter int FFT_SIZE    = 16,
   parameter int WORD_SIZE   = 16,
   parameter int DATA_LENGTH = 8,
   parameter int FRACTION    = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_rx_valid,
   input  logic [DATA_LENGTH-1:0]     i_rx_byte,
   output logic                       o_sample_we,
   output logic [$clog2(FFT_SIZE)-1:0] o_sample_addr,
   output logic [WORD_SIZE-1:0]       o_sample_data,
   output logic                       o_fft_start,
   input  logic                       i_fft_done,
   output logic [$clog2(FFT_SIZE)-1:0] o_res_addr,
   input  logic [WORD_SIZE-1:0]       i_res_re,
   input  logic [WORD_SIZE-1:0]       i_res_im,
   output logic                       o_tx_start,
   output logic [DATA_LENGTH-1:0]     o_tx_byte,
   input  logic                       i_tx_done,
   output logic                       o_busy,
   output logic                       o_frame_done,
   output logic                       o_error
);
   localparam int AW  = $clog2(FFT_SIZE);
   localparam int BPW = WORD_SIZE / DATA_LENGTH;
   localparam int NB  = 2 * BPW;
   localparam int CW  = $clog2(NB + 1);
   localparam logic [2:0] RECV     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] WAIT_FFT = 3'd2;
   localparam logic [2:0] READ     = 3'd3;
   localparam logic [2:0] LATCH    = 3'd4;
   localparam logic [2:0] SEND     = 3'd5;
   localparam logic [2:0] WAIT_TX  = 3'd6;
   logic [2:0]             state;
   logic [AW-1:0]          smp_cnt, bin;
   logic [CW-1:0]          byte_cnt, byte_nx;
   logic [2*WORD_SIZE-1:0] shreg;
   logic [WORD_SIZE-1:0]   sext;
   logic                   last_smp, last_bin;
   assign sext       = WORD_SIZE'($signed(i_rx_byte));
   assign byte_nx    = byte_cnt + CW'(1);
   assign last_smp   = smp_cnt == AW'(FFT_SIZE - 1);
   assign last_bin   = bin == AW'(FFT_SIZE - 1);
   assign o_res_addr = bin;
   // TX start and byte come straight from the state so the first byte leaves the cycle after LATCH
   assign o_tx_start = state == SEND;
   assign o_tx_byte  = shreg[2*WORD_SIZE-1 -: DATA_LENGTH];
   assign o_busy     = state != RECV || smp_cnt != '0;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= RECV;
         smp_cnt       <= '0;
         bin           <= '0;
         byte_cnt      <= '0;
         shreg         <= '0;
         o_sample_we   <= 1'b0;
         o_sample_addr <= '0;
         o_sample_data <= '0;
         o_fft_start   <= 1'b0;
         o_frame_done  <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         o_sample_we  <= i_rx_valid && state == RECV;
         o_fft_start  <= state == START;
         o_frame_done <= 1'b0;
         if (i_rx_valid && state == RECV) begin
            o_sample_addr <= smp_cnt;
            o_sample_data <= sext << FRACTION;
         end
         // bytes arriving outside RECV are dropped but remembered until reset
         if (i_rx_valid && state != RECV) o_error <= 1'b1;
         case (state)
            RECV: if (i_rx_valid) begin
               smp_cnt <= smp_cnt + AW'(1);
               if (last_smp) state <= START;
            end
            START: state <= WAIT_FFT;
            WAIT_FFT: if (i_fft_done) begin
               bin   <= '0;
               state <= READ;
            end
            READ: state <= LATCH;
            LATCH: begin
               shreg    <= {i_res_re, i_res_im};
               byte_cnt <= '0;
               state    <= SEND;
            end
            SEND: state <= WAIT_TX;
            WAIT_TX: if (i_tx_done) begin
               shreg    <= shreg << DATA_LENGTH;
               byte_cnt <= byte_nx;
               if (byte_nx < CW'(NB)) state <= SEND;
               else if (!last_bin) begin
                  bin   <= bin + AW'(1);
                  state <= READ;
               end else begin
                  o_frame_done <= 1'b1;
                  state        <= RECV;
               end
            end
            default: state <= RECV;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_frame_controller.sv
// tb_fft_frame_controller: random sample frames and FFT results, scoreboarded against
// a frame-level model of the expected buffer writes and UART byte stream.
module tb_fft_frame_controller;
   localparam int N = 16;
   localparam int TX_DLY = 10;
   logic        i_clk = 0, i_rst = 1, i_rx_valid = 0, i_fft_done = 0;
   logic [7:0]  i_rx_byte = 0;
   logic [15:0] i_res_re = 0, i_res_im = 0;
   logic        model_done = 0, stale_done = 0, i_tx_done;
   logic        o_sample_we, o_fft_start, o_tx_start, o_busy, o_frame_done, o_error;
   logic [3:0]  o_sample_addr, o_res_addr;
   logic [15:0] o_sample_data;
   logic [7:0]  o_tx_byte, held_byte;
   logic [15:0] re_mem [N];
   logic [15:0] im_mem [N];
   logic [19:0] wr_q [$];
   logic [11:0] tx_q [$];
   int ncyc = 0, n_vec = 0, n_err = 0, fs_cnt = 0, fd_cnt = 0, tx_pops = 0, base = 0;
   int exp_fs_n = 0, exp_first_n = 0, last_done_n = 0, tx_seen = 0, hold_at = -1;
   int tx_wait = 0, smp_idx = 0;
   assign i_tx_done = model_done | stale_done;
   fft_frame_controller dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
      .o_sample_we(o_sample_we), .o_sample_addr(o_sample_addr), .o_sample_data(o_sample_data),
      .o_fft_start(o_fft_start), .i_fft_done(i_fft_done), .o_res_addr(o_res_addr),
      .i_res_re(i_res_re), .i_res_im(i_res_im), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
      .i_tx_done(i_tx_done), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error)
   );
   always #5 i_clk = ~i_clk;
   initial forever begin
      @(posedge i_clk);
      ncyc++;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
      end
   endtask
   // result RAM with one cycle read latency
   initial forever begin
      @(posedge i_clk);
      i_res_re <= re_mem[o_res_addr];
      i_res_im <= im_mem[o_res_addr];
   end
   // UART TX model: done pulse TX_DLY cycles after each start, optionally withheld once
   initial forever begin
      @(negedge i_clk);
      model_done = 0;
      if (i_rst) tx_wait = 0;
      else if (tx_wait > 0) begin
         tx_wait--;
         if (tx_wait == 0) begin
            model_done = 1;
            last_done_n = ncyc;
            chk("tx_byte_stable", o_tx_byte, held_byte);
         end
      end
      if (o_tx_start) begin
         tx_seen++;
         held_byte = o_tx_byte;
         if (tx_seen != hold_at) tx_wait = TX_DLY;
      end
   end
   // monitor: pops the scoreboard whenever the DUT presents an output event
   initial forever begin
      logic [19:0] w;
      logic [11:0] t;
      int k;
      @(negedge i_clk);
      if (o_sample_we) begin
         chk("write_expected", wr_q.size() != 0, 1);
         if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("write_addr_data", {o_sample_addr, o_sample_data}, w);
         end
      end
      if (o_tx_start) begin
         k = tx_pops - base;
         chk("tx_expected", tx_q.size() != 0, 1);
         if (tx_q.size() != 0) begin
            t = tx_q.pop_front();
            chk("tx_addr_byte", {o_res_addr, o_tx_byte}, t);
         end
         chk("tx_timing", ncyc, k == 0 ? exp_first_n : last_done_n + (k % 4 == 0 ? 3 : 1));
         tx_pops++;
      end
      if (o_fft_start) begin
         fs_cnt++;
         chk("fft_start_time", ncyc, exp_fs_n);
      end
      if (o_frame_done) begin
         fd_cnt++;
         chk("frame_done_time", ncyc, last_done_n + 1);
         chk("busy_after_frame", o_busy, 0);
         chk("frame_bytes", tx_pops - base, 64);
      end
   end
   task automatic send_byte(input logic [7:0] b, input logic exp_wr);
      int v;
      v = $signed(b);
      if (exp_wr) begin
         wr_q.push_back({4'(smp_idx), 16'(v * 256)});
         smp_idx = (smp_idx + 1) % N;
         if (smp_idx == 0) exp_fs_n = ncyc + 2;
      end
      i_rx_valid = 1;
      i_rx_byte  = b;
      @(negedge i_clk);
      i_rx_valid = 0;
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
   endtask
   task automatic recv_frame(input logic [7:0] b0, input logic [7:0] b1, input int mode);
      logic [7:0] b;
      for (int k = 0; k < N; k++) begin
         b = mode == 0 ? 8'(k) : k == 0 ? b0 : k == 1 ? b1 : 8'($urandom);
         send_byte(b, 1);
         if (k == 0) chk("busy_recv", o_busy, 1);
      end
   endtask
   task automatic wait_fs(input int tgt);
      for (int i = 0; i < 100 && fs_cnt < tgt; i++) @(negedge i_clk);
      chk("fft_start_count", fs_cnt, tgt);
   endtask
   task automatic wait_fd(input int tgt);
      for (int i = 0; i < 3000 && fd_cnt < tgt; i++) @(negedge i_clk);
      chk("frame_done_count", fd_cnt, tgt);
   endtask
   task automatic run_fft(input int hold_bin, input logic fixed0);
      for (int b = 0; b < N; b++) begin
         re_mem[b] = 16'($urandom);
         im_mem[b] = 16'($urandom);
      end
      if (fixed0) begin
         re_mem[0] = 16'h1234;
         im_mem[0] = 16'hABCD;
      end
      for (int b = 0; b < N; b++) begin
         tx_q.push_back({4'(b), re_mem[b][15:8]});
         tx_q.push_back({4'(b), re_mem[b][7:0]});
         tx_q.push_back({4'(b), im_mem[b][15:8]});
         tx_q.push_back({4'(b), im_mem[b][7:0]});
      end
      repeat (2) @(negedge i_clk);
      base = tx_pops;
      hold_at = hold_bin < 0 ? -1 : tx_seen + hold_bin * 4 + 2;
      i_fft_done = 1;
      exp_first_n = ncyc + 3;
      @(negedge i_clk);
      i_fft_done = 0;
   endtask
   task automatic check_zero(input string nm);
      chk({nm, "_outs_a"}, {o_sample_we, o_sample_addr, o_sample_data, o_fft_start, o_res_addr}, 0);
      chk({nm, "_outs_b"}, {o_tx_start, o_tx_byte, o_busy, o_frame_done, o_error}, 0);
   endtask
   initial begin
      int s;
      repeat (3) @(negedge i_clk);
      i_rst = 0;
      check_zero("reset");
      // frame A: ramp samples, fixed first bin
      recv_frame(0, 0, 0);
      wait_fs(1);
      run_fft(-1, 1);
      wait_fd(1);
      chk("no_error_a", o_error, 0);
      // frame B: sign-extension corner bytes plus an overrun during WAIT_FFT
      recv_frame(8'hFF, 8'h80, 1);
      wait_fs(2);
      send_byte(8'h5A, 0);
      chk("overrun_error", o_error, 1);
      run_fft(-1, 0);
      wait_fd(2);
      // frame C: aborted by reset while waiting on a TX byte of bin 5
      recv_frame(8'($urandom), 8'($urandom), 1);
      wait_fs(3);
      chk("error_sticky", o_error, 1);
      run_fft(5, 0);
      for (int i = 0; i < 3000 && tx_seen < hold_at; i++) @(negedge i_clk);
      chk("hold_reached", tx_seen, hold_at);
      repeat (3) @(negedge i_clk);
      i_rst = 1;
      wr_q.delete();
      tx_q.delete();
      smp_idx = 0;
      @(negedge i_clk);
      i_rst = 0;
      hold_at = -1;
      check_zero("mid_reset");
      s = tx_seen;
      stale_done = 1;
      i_fft_done = 1;
      @(negedge i_clk);
      stale_done = 0;
      i_fft_done = 0;
      repeat (3) @(negedge i_clk);
      chk("stale_busy", o_busy, 0);
      chk("stale_no_tx", tx_seen, s);
      chk("stale_no_start", fs_cnt, 3);
      // frame D: first byte after reset lands at address 0
      recv_frame(8'($urandom), 8'($urandom), 1);
      wait_fs(4);
      run_fft(-1, 0);
      wait_fd(3);
      chk("no_error_d", o_error, 0);
      chk("queues_drained", wr_q.size() + tx_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", ncyc);
      $fatal(1);
   end
endmodule
